// File: rtl/inst_sequencer.sv
// inst_sequencer: steps through stored instruction programs one word per rising edge of step,
// with optional looping, abort and run-time program/length rewrite.
module inst_sequencer #(
    parameter int INST_W   = 8,
    parameter int NUM_PROG = 4,
    parameter int DEPTH    = 32,
    parameter int SEL_W    = $clog2(NUM_PROG),
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int LEN_W    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              abort,
    input  logic              step,
    input  logic [SEL_W-1:0]  sel,
    input  logic              loop,
    input  logic              wr_en,
    input  logic [SEL_W-1:0]  wr_prog,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [INST_W-1:0] wr_data,
    input  logic              len_wr,
    input  logic [LEN_W-1:0]  wr_len,
    output logic [INST_W-1:0] inst,
    output logic              inst_valid,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              done
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [INST_W-1:0] mem [NUM_PROG][DEPTH];
    logic [LEN_W-1:0]  len [NUM_PROG];
    logic [0:0]        state;
    logic [SEL_W-1:0]  cur_prog;
    logic [LEN_W-1:0]  nxt;
    logic              step_q;
    logic              armed;
    logic              run;
    logic              ev;
    logic              hit;
    logic              go;
    logic [SEL_W-1:0]  prog;
    logic [LEN_W-1:0]  prog_len;
    logic [ADDR_W-1:0] addr;

    // armed blocks a step that is already high when reset releases until it has been seen low
    always_comb begin
        run      = state == RUN;
        ev       = step & ~step_q & armed;
        prog     = run ? cur_prog : sel;
        prog_len = len[prog];
        hit      = run && nxt < prog_len;
        addr     = hit ? nxt[ADDR_W-1:0] : '0;
        go       = hit || (run ? loop : prog_len != '0);
    end

    assign busy = run;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_prog][wr_addr] <= wr_data;
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state      <= IDLE;
            cur_prog   <= '0;
            nxt        <= '0;
            step_q     <= 1'b0;
            armed      <= 1'b0;
            inst       <= '0;
            pc         <= '0;
            inst_valid <= 1'b0;
            done       <= 1'b0;
            for (int i = 0; i < NUM_PROG; i++) len[i] <= '0;
        end else begin
            step_q     <= step;
            armed      <= armed | ~step;
            inst_valid <= 1'b0;
            done       <= 1'b0;
            if (len_wr) len[wr_prog] <= wr_len > LEN_W'(DEPTH) ? LEN_W'(DEPTH) : wr_len;
            if (abort) begin
                state <= IDLE;
                nxt   <= '0;
            end else if (ev) begin
                done <= run ? !hit : prog_len == '0;
                if (go) begin
                    state      <= RUN;
                    cur_prog   <= prog;
                    inst       <= mem[prog][addr];
                    pc         <= addr;
                    inst_valid <= 1'b1;
                    nxt        <= LEN_W'(addr) + LEN_W'(1);
                end else begin
                    state <= IDLE;
                    nxt   <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_inst_sequencer.sv
// tb_inst_sequencer: directed and random stimulus against a position-based program model,
// expected pulses queued by the driver and checked by an independent negedge monitor.
module tb_inst_sequencer;
    logic       clk = 0;
    logic       clr_n, abort, step, loop, wr_en, len_wr;
    logic [1:0] sel, wr_prog;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic [5:0] wr_len;
    logic [7:0] inst;
    logic       inst_valid, busy, done;
    logic [4:0] pc;

    typedef struct packed {
        logic       v;
        logic       d;
        logic [7:0] inst;
        logic [4:0] pc;
        logic       busy;
    } rec_t;

    rec_t q[$];
    rec_t act, want;
    int   compared = 0, mismatched = 0;

    int m_mem[4][32];
    int m_len[4];
    bit m_run, m_low;
    int m_cur, m_pos, m_inst, m_pc;

    inst_sequencer dut (
        .clk(clk), .clr_n(clr_n), .abort(abort), .step(step), .sel(sel), .loop(loop),
        .wr_en(wr_en), .wr_prog(wr_prog), .wr_addr(wr_addr), .wr_data(wr_data),
        .len_wr(len_wr), .wr_len(wr_len), .inst(inst), .inst_valid(inst_valid),
        .pc(pc), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (clr_n && (inst_valid || done || q.size() != 0)) begin
            act  = {inst_valid, done, inst, pc, busy};
            want = q.size() != 0 ? q.pop_front() : '0;
            compared++;
            if (act !== want) begin
                mismatched++;
                $display("FAIL scoreboard t=%0t got v=%b d=%b inst=%h pc=%0d busy=%b want v=%b d=%b inst=%h pc=%0d busy=%b",
                         $time, act.v, act.d, act.inst, act.pc, act.busy,
                         want.v, want.d, want.inst, want.pc, want.busy);
            end
        end
    end

    task automatic chk(string name, logic [31:0] a, logic [31:0] x);
        compared++;
        if (a !== x) begin
            mismatched++;
            $display("FAIL %s got %0h want %0h", name, a, x);
        end
    endtask

    task automatic model_reset();
        foreach (m_len[i]) m_len[i] = 0;
        m_run = 0; m_low = 0; m_inst = 0; m_pc = 0; m_cur = 0; m_pos = 0;
    endtask

    // model of one clock edge using the inputs currently driven; pulse expectations queued after the edge
    task automatic cyc();
        bit   ev;
        rec_t e;
        ev = step && m_low;
        e  = '0;
        if (abort) m_run = 0;
        else if (ev) begin
            if (!m_run) begin
                if (m_len[sel] == 0) e.d = 1;
                else begin m_cur = sel; m_pos = 0; m_run = 1; e.v = 1; end
            end else if (m_pos + 1 < m_len[m_cur]) begin
                m_pos++; e.v = 1;
            end else begin
                e.d = 1;
                if (loop) begin m_pos = 0; e.v = 1; end
                else m_run = 0;
            end
        end
        if (e.v) begin m_inst = m_mem[m_cur][m_pos]; m_pc = m_pos; end
        e.inst = 8'(m_inst); e.pc = 5'(m_pc); e.busy = m_run;
        if (wr_en) m_mem[wr_prog][wr_addr] = int'(wr_data);
        if (len_wr) m_len[wr_prog] = wr_len > 32 ? 32 : int'(wr_len);
        m_low = !step;
        @(posedge clk); #1;
        if (e.v || e.d) q.push_back(e);
    endtask

    task automatic wr(int p, int a, int d);
        wr_en = 1; wr_prog = 2'(p); wr_addr = 5'(a); wr_data = 8'(d);
        cyc();
        wr_en = 0;
    endtask

    task automatic ln(int p, int l);
        len_wr = 1; wr_prog = 2'(p); wr_len = 6'(l);
        cyc();
        len_wr = 0;
    endtask

    task automatic pulse();
        step = 1; cyc();
        step = 0; cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        clr_n = 0; abort = 0; step = 0; loop = 0; sel = 0;
        wr_en = 0; wr_prog = 0; wr_addr = 0; wr_data = 0; len_wr = 0; wr_len = 0;
        model_reset();
        #12;
        chk("rst_inst", 32'(inst), 0);
        chk("rst_pc", 32'(pc), 0);
        chk("rst_valid", 32'(inst_valid), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_busy", 32'(busy), 0);
        @(negedge clk); clr_n = 1;
        for (int p = 0; p < 4; p++)
            for (int a = 0; a < 32; a++) wr(p, a, int'($urandom_range(0, 255)));

        wr(1, 0, 'h36); wr(1, 1, 'h24); wr(1, 2, 'h70); ln(1, 3);
        sel = 1; loop = 0;
        repeat (4) pulse();
        chk("prog1_end_busy", 32'(busy), 0);

        loop = 1;
        repeat (5) pulse();
        chk("loop_busy", 32'(busy), 1);
        loop = 0; abort = 1; cyc(); abort = 0;
        chk("abort_idle", 32'(busy), 0);

        ln(2, 0); sel = 2;
        pulse();
        chk("len0_busy", 32'(busy), 0);

        sel = 1; pulse();
        step = 1; repeat (10) cyc();
        step = 0; cyc();
        step = 1; abort = 1; cyc();
        chk("abort_step_busy", 32'(busy), 0);
        step = 0; abort = 0; cyc();

        ln(0, 4); sel = 0;
        pulse(); pulse();
        chk("p0_pc1", 32'(pc), 1);
        len_wr = 1; wr_prog = 0; wr_len = 2; sel = 3; cyc(); len_wr = 0;
        pulse();
        chk("shrink_done_busy", 32'(busy), 0);

        ln(0, 40); sel = 0;
        pulse(); pulse();
        @(negedge clk); #1; clr_n = 0; #1;
        chk("mid_rst_inst", 32'(inst), 0);
        chk("mid_rst_pc", 32'(pc), 0);
        chk("mid_rst_valid", 32'(inst_valid), 0);
        chk("mid_rst_done", 32'(done), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        q.delete(); model_reset();
        step = 1;
        @(negedge clk); clr_n = 1;
        repeat (3) cyc();
        step = 0; cyc();
        pulse();

        repeat (1500) begin
            wr_en = $urandom_range(0, 3) == 0; wr_prog = 2'($urandom_range(0, 3));
            wr_addr = 5'($urandom_range(0, 31)); wr_data = 8'($urandom_range(0, 255));
            len_wr = $urandom_range(0, 11) == 0; wr_len = 6'($urandom_range(0, 33));
            abort = $urandom_range(0, 29) == 0; loop = 1'($urandom_range(0, 1));
            sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) step = !step;
            cyc();
            chk("rand_busy", 32'(busy), 32'(m_run));
        end
        wr_en = 0; len_wr = 0; abort = 0; step = 0;
        repeat (3) cyc();
        chk("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/inst_sequencer.md
INST_SEQUENCER -- requirements
Module: inst_sequencer

Interface
REQ-001 Parameter INST_W, default 8, instruction word width.
REQ-002 Parameter NUM_PROG, default 4, number of stored programs (>=2).
REQ-003 Parameter DEPTH, default 32, max instructions per program (>=2).
REQ-004 Derived: SEL_W=clog2(NUM_PROG), ADDR_W=clog2(DEPTH), LEN_W=clog2(DEPTH+1).
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 clr_n  input  1  reset, asynchronous assert, active-low.
REQ-007 abort  input  1  synchronous abort of running program.
REQ-008 step  input  1  advance request, level; rising edge detected internally in clk domain.
REQ-009 sel  input  SEL_W  program select, sampled only at program start.
REQ-010 loop  input  1  1 = restart at address 0 after last instruction, sampled at end of program.
REQ-011 wr_en  input  1  instruction write strobe.
REQ-012 wr_prog  input  SEL_W  program index for instruction or length write.
REQ-013 wr_addr  input  ADDR_W  instruction address for write.
REQ-014 wr_data  input  INST_W  instruction word to write.
REQ-015 len_wr  input  1  program length write strobe; value taken from wr_len.
REQ-016 wr_len  input  LEN_W  program length, 0..DEPTH.
REQ-017 inst  output  INST_W  current instruction, registered.
REQ-018 inst_valid  output  1  one-cycle pulse when inst updates.
REQ-019 pc  output  ADDR_W  address of instruction on inst.
REQ-020 busy  output  1  high in RUN state.
REQ-021 done  output  1  one-cycle pulse at program completion.

Function
REQ-022 Storage: NUM_PROG x DEPTH x INST_W array plus NUM_PROG x LEN_W length table.
REQ-023 Step event = step high this cycle, low previous cycle; held step yields exactly one event.
REQ-024 States: IDLE, RUN; cur_prog (SEL_W) and nxt (LEN_W) registers.
REQ-025 IDLE + step event, len[sel]==0: done pulses next cycle, stay IDLE, inst_valid stays 0.
REQ-026 IDLE + step event, len[sel]>0: latch cur_prog=sel; next cycle inst=mem[sel][0], pc=0, inst_valid=1, nxt=1, -> RUN.
REQ-027 RUN + step event, nxt<len[cur_prog]: next cycle inst=mem[cur_prog][nxt], pc=nxt, inst_valid=1, nxt+=1.
REQ-028 RUN + step event, nxt==len[cur_prog] (or nxt>len after length rewrite), loop=0: next cycle done=1, inst_valid=0, -> IDLE; inst and pc hold.
REQ-029 Same with loop=1: next cycle done=1 and inst=mem[cur_prog][0], pc=0, inst_valid=1, nxt=1, stay RUN.
REQ-030 Latency: step event at edge N -> inst/inst_valid/done at edge N+1.
REQ-031 inst and pc hold their last value between valid pulses.
REQ-032 abort high: next cycle -> IDLE, nxt=0, inst_valid=0, done=0; inst/pc hold; abort beats a simultaneous step event.
REQ-033 Instruction write: mem[wr_prog][wr_addr]<=wr_data at edge; a same-cycle read of that address returns the old word.
REQ-034 Length write: wr_len>DEPTH stores DEPTH; takes effect at the next step event, including for a running program.
REQ-035 wr_en and len_wr may be asserted together and in any state; both complete.
REQ-036 sel changes during RUN are ignored until next IDLE start.

Reset
REQ-037 clr_n low: immediately state=IDLE, inst=0, pc=0, inst_valid=0, done=0, busy=0, nxt=0, cur_prog=0, step history=0, all lengths=0.
REQ-038 Instruction array contents are not reset; reset mid-program discards progress without a done pulse.
REQ-039 First step event after reset release with step already high is not detected until step falls and rises.

Verification
REQ-040 Load prog 1 = {0x36,0x24,0x70}, len 3, sel=1, loop=0; four step pulses -> inst 0x36,0x24,0x70 with pc 0,1,2, fourth gives done=1, busy=0.
REQ-041 Same program, loop=1; five step pulses -> 0x36,0x24,0x70, then 0x36 with done=1 on the same cycle, then 0x24.
REQ-042 len[2]=0, sel=2; one step -> done=1 next cycle, no inst_valid, busy stays 0.
REQ-043 Step held high 10 cycles in RUN -> exactly one inst_valid; abort together with a step event -> no inst_valid, busy=0 next cycle.
REQ-044 Running prog 0 at pc=1; write len[0]=2 and sel=3 -> next step gives done, sel ignored; clr_n low mid-run -> all outputs 0 without waiting for clk.
